// File: rtl/vga_frame_arbiter.sv
// Single-port pixel SRAM arbiter: raster-order prefetch into a small FIFO for VGA scan-out,
// with writer traffic interleaved whenever FIFO occupancy allows.
module vga_frame_arbiter #(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned LOW_WATER    = 4,
    parameter int unsigned FRAME_PIXELS = 307200
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic              i_pix_req,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid,
    output logic              o_underflow,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_we,
    output logic              o_sram_re,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [OCC_W-1:0]  OCC_LOW   = OCC_W'(LOW_WATER);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;
    typedef enum logic [1:0] {GntNone, GntRead, GntWrite} grant_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic                sram_we_q, sram_we_d;
    logic                sram_re_q, sram_re_d;
    logic                rvalid_q, rvalid_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]    fifo_wp_q, fifo_wp_d;
    logic [PTR_W-1:0]    fifo_rp_q, fifo_rp_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   pix_data_q, pix_data_d;
    logic                pix_valid_q, pix_valid_d;
    logic                underflow_q, underflow_d;

    grant_e              grant;
    logic                fetch;
    logic                rd_go;
    logic                wr_go;
    logic                push;
    logic                pop;
    logic [OCC_W-1:0]    occ;

    always_comb begin
        // Occupancy counts reads still in flight so a full FIFO can never be overrun.
        occ   = OCC_W'(fifo_cnt_q) + OCC_W'(sram_re_q) + OCC_W'(rvalid_q);
        fetch = (state_q == StFetch);
        grant = GntNone;
        if (fetch && (occ < OCC_LOW)) begin
            grant = GntRead;
        end else if (i_wr_valid) begin
            grant = GntWrite;
        end else if (fetch && (occ < OCC_FULL)) begin
            grant = GntRead;
        end
        rd_go = (grant == GntRead) && !i_frame_start;
        wr_go = (grant == GntWrite);
        push  = rvalid_q && !i_frame_start;
        pop   = i_pix_req && (fifo_cnt_q != '0) && !i_frame_start;
    end

    assign o_wr_ready = wr_go && i_rst_n;

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_d    = wr_go;
        sram_re_d    = rd_go;
        rvalid_d     = sram_re_q && !i_frame_start;
        fifo_cnt_d   = fifo_cnt_q;
        fifo_wp_d    = fifo_wp_q;
        fifo_rp_d    = fifo_rp_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        underflow_d  = underflow_q;

        if (i_frame_start) begin
            state_d  = StFetch;
            rd_ptr_d = '0;
        end else if (rd_go) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (rd_ptr_q == LAST_ADDR) begin
                state_d = StDone;
            end
        end

        if (rd_go) begin
            sram_addr_d = rd_ptr_q;
        end else if (wr_go) begin
            sram_addr_d  = i_wr_addr;
            sram_wdata_d = i_wr_data;
        end

        if (i_frame_start) begin
            fifo_cnt_d = '0;
            fifo_wp_d  = '0;
            fifo_rp_d  = '0;
        end else begin
            if (push) begin
                fifo_wp_d = fifo_wp_q + PTR_W'(1);
            end
            if (pop) begin
                fifo_rp_d = fifo_rp_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            end
        end

        // A request coinciding with frame start is answered with a blank, not an underflow.
        if (i_frame_start) begin
            underflow_d = 1'b0;
            if (i_pix_req) begin
                pix_data_d = '0;
            end
        end else if (i_pix_req) begin
            if (fifo_cnt_q != '0) begin
                pix_data_d  = fifo_mem_q[fifo_rp_q];
                pix_valid_d = 1'b1;
            end else begin
                pix_data_d  = '0;
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            fifo_cnt_q   <= '0;
            fifo_wp_q    <= '0;
            fifo_rp_q    <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_q    <= sram_we_d;
            sram_re_q    <= sram_re_d;
            rvalid_q     <= rvalid_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo_wp_q    <= fifo_wp_d;
            fifo_rp_q    <= fifo_rp_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            underflow_q  <= underflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[fifo_wp_q] <= i_sram_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(push && !pop && (fifo_cnt_q == CNT_FULL)))
            else $error("vga_frame_arbiter: prefetch fifo overflow");
        end
    end

    assign o_pix_data   = pix_data_q;
    assign o_pix_valid  = pix_valid_q;
    assign o_underflow  = underflow_q;
    assign o_busy       = (state_q == StFetch);
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_wdata = sram_wdata_q;
    assign o_sram_we    = sram_we_q;
    assign o_sram_re    = sram_re_q;

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Directed bench for vga_frame_arbiter with a 16-pixel frame and a behavioural SRAM
// whose unwritten words read back their own address.
module tb_vga_frame_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fs = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          pix_req = 1'b0;
    logic [DW-1:0] sram_rdata = '0;

    logic          o_wr_ready;
    logic [DW-1:0] o_pix_data;
    logic          o_pix_valid;
    logic          o_underflow;
    logic          o_busy;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] o_sram_wdata;
    logic          o_sram_we;
    logic          o_sram_re;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW:0]   exp_q [$];
    logic [AW-1:0] rd_log [$];
    logic [DW-1:0] wmem [int];

    vga_frame_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .FIFO_DEPTH  (8),
        .LOW_WATER   (4),
        .FRAME_PIXELS(16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_start(fs),
        .i_wr_valid   (wr_valid),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_ready   (o_wr_ready),
        .i_pix_req    (pix_req),
        .o_pix_data   (o_pix_data),
        .o_pix_valid  (o_pix_valid),
        .o_underflow  (o_underflow),
        .o_busy       (o_busy),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_we    (o_sram_we),
        .o_sram_re    (o_sram_re),
        .i_sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_sram_re) begin
            sram_rdata <= wmem.exists(int'(o_sram_addr)) ? wmem[int'(o_sram_addr)]
                                                         : DW'(o_sram_addr);
        end
        if (o_sram_we) begin
            wmem[int'(o_sram_addr)] = o_sram_wdata;
        end
    end

    always @(negedge clk) begin
        if (o_sram_re) begin
            rd_log.push_back(o_sram_addr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({o_wr_ready, o_pix_data, o_pix_valid, o_underflow, o_busy,
                    o_sram_addr, o_sram_wdata, o_sram_we, o_sram_re});
    endfunction

    // One request cycle; expectation queued at drive time, compared when the answer appears.
    task automatic pix(input logic exp_v, input logic [DW-1:0] exp_d);
        logic [DW:0] want;
        pix_req = 1'b1;
        exp_q.push_back({exp_v, exp_d});
        tick();
        pix_req = 1'b0;
        want = exp_q.pop_front();
        check("pix", 64'({o_pix_valid, o_pix_data}), 64'(want));
    endtask

    initial begin
        // Reset, with a writer waiting
        #1 rst_n = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 20'h00055;
        wr_data  = 16'h5555;
        #1;
        check("rst_wr_ready", 64'(o_wr_ready), 64'(0));
        tick();
        tick();
        check("rst_outputs", outs(), 64'(0));
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("idle_no_read", 64'(o_sram_re), 64'(0));
        check("idle_not_busy", 64'(o_busy), 64'(0));

        // Frame 1: prefetch fill, spaced requests, frame end
        rd_log.delete();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("busy_fetch", 64'(o_busy), 64'(1));
        repeat (12) tick();
        check("fill_reads", 64'(rd_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) check("fill_addr", 64'(rd_log[i]), 64'(i));
        check("re_idle_full", 64'(o_sram_re), 64'(0));
        for (int i = 0; i < 8; i++) begin
            pix(1'b1, DW'(i));
            tick();
        end
        repeat (10) tick();
        check("done_not_busy", 64'(o_busy), 64'(0));
        check("frame_reads", 64'(rd_log.size()), 64'(16));
        for (int i = 8; i < 16; i++) check("frame_addr", 64'(rd_log[i]), 64'(i));
        for (int i = 8; i < 16; i++) pix(1'b1, DW'(i));
        check("no_uf_yet", 64'(o_underflow), 64'(0));
        pix(1'b0, '0);
        check("uf_17th", 64'(o_underflow), 64'(1));

        // Frame 2: request every cycle from frame start
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("uf_cleared", 64'(o_underflow), 64'(0));
        for (int k = 0; k < 19; k++) begin
            pix(k >= 3, (k >= 3) ? DW'(k - 3) : '0);
            check("uf_sticky", 64'(o_underflow), 64'(1));
        end
        check("stream_done", 64'(o_busy), 64'(0));

        // Frame 3: writer against a full FIFO, then read urgency takes over
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("uf_cleared2", 64'(o_underflow), 64'(0));
        repeat (12) tick();
        wr_valid = 1'b1;
        wr_addr  = 20'h00100;
        wr_data  = 16'hABCD;
        #1;
        check("wr_ready_full", 64'(o_wr_ready), 64'(1));
        tick();
        check("wr_we", 64'(o_sram_we), 64'(1));
        check("wr_addr", 64'(o_sram_addr), 64'h100);
        check("wr_wdata", 64'(o_sram_wdata), 64'hABCD);
        check("wr_no_re", 64'(o_sram_re), 64'(0));
        for (int i = 0; i < 5; i++) pix(1'b1, DW'(i));
        check("rd_wins_ready", 64'(o_wr_ready), 64'(0));
        tick();
        check("rd_wins_re", 64'(o_sram_re), 64'(1));
        check("rd_wins_addr", 64'(o_sram_addr), 64'(8));
        check("wr_ready_back", 64'(o_wr_ready), 64'(1));
        wr_valid = 1'b0;

        // Frame 4: restart with two reads in flight and five pixels buffered
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (7) tick();
        fs = 1'b1;
        pix(1'b0, '0);
        fs = 1'b0;
        check("restart_no_uf", 64'(o_underflow), 64'(0));
        check("restart_cancel_re", 64'(o_sram_re), 64'(0));
        tick();
        check("restart_re", 64'(o_sram_re), 64'(1));
        check("restart_addr0", 64'(o_sram_addr), 64'(0));
        pix(1'b0, '0);
        check("restart_flushed", 64'(o_underflow), 64'(1));
        tick();
        pix(1'b1, DW'(0));
        pix(1'b1, DW'(1));

        // Reset mid-frame with a write pending
        wr_valid = 1'b1;
        wr_addr  = 20'h00200;
        wr_data  = 16'h1234;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outs", outs(), 64'(0));
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(o_wr_ready), 64'(1));
        tick();
        check("post_rst_we", 64'(o_sram_we), 64'(1));
        check("post_rst_addr", 64'(o_sram_addr), 64'h200);
        check("post_rst_idle", 64'(o_busy), 64'(0));
        repeat (4) begin
            tick();
            check("post_rst_no_read", 64'(o_sram_re), 64'(0));
        end
        wr_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
